// File: rtl/reg_seq_ctrl_pkg.sv
// Shared definitions for the register-file sequencer: phase codes,
// opcode constants and the instruction field layout
// {op[15:12], Rd1[11:8], Rd2[7:4], Wr[3:0]}.
package reg_seq_ctrl_pkg;

    localparam int INSTR_W = 16;

    // Phase codes seen by the register file on pst
    localparam logic [2:0] S0 = 3'b000;  // IDLE
    localparam logic [2:0] S1 = 3'b001;  // DECODE
    localparam logic [2:0] S2 = 3'b010;  // RD1
    localparam logic [2:0] S3 = 3'b011;  // RD2
    localparam logic [2:0] S4 = 3'b100;  // WRADR
    localparam logic [2:0] S5 = 3'b101;  // WRITE
    localparam logic [2:0] S6 = 3'b110;  // DONE
    localparam logic [2:0] S7 = 3'b111;  // HALT/TRAP

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction field MSB positions; each field extends downward
    localparam int OP_MSB  = 15;
    localparam int RD1_MSB = 11;
    localparam int RD2_MSB = 7;
    localparam int WR_MSB  = 3;

endpackage

// File: rtl/reg_seq_decode.sv
// Combinational field decode of the latched instruction word.
module reg_seq_decode
    import reg_seq_ctrl_pkg::*;
#(
    parameter int ADDRW = 4,
    parameter int OPW   = 4
) (
    input  logic [INSTR_W-1:0] i_instr,
    output logic [OPW-1:0]     o_op,
    output logic [ADDRW-1:0]   o_rd1,
    output logic [ADDRW-1:0]   o_rd2,
    output logic [ADDRW-1:0]   o_wr,
    output logic               o_is_nop,
    output logic               o_is_halt
);

    assign o_op      = i_instr[OP_MSB  -: OPW];
    assign o_rd1     = i_instr[RD1_MSB -: ADDRW];
    assign o_rd2     = i_instr[RD2_MSB -: ADDRW];
    assign o_wr      = i_instr[WR_MSB  -: ADDRW];
    assign o_is_nop  = (o_op == OPW'(OP_NOP));
    assign o_is_halt = (o_op == OPW'(OP_HALT));

endmodule

// File: rtl/reg_seq_ctrl.sv
// Instruction sequencer for the 16x4 register file, ALU and write-back.
// One instruction is accepted in IDLE, then the phase walks
// DECODE, RD1, RD2, WRADR, WRITE, DONE back to IDLE (7 cycles per instruction).
// Optional feature macro: OVF_TRAP_EN -- an ALU overflow on a real write
// traps to S7 until trap_clr; without it overflow/trap_clr are ignored.
//
// state | meaning
// S0    | idle, instr_ready=1, accepting
// S1    | decode latched word
// S2    | read Rd1
// S3    | read Rd2
// S4    | latch write address
// S5    | write (Reg_Write unless NOP)
// S6    | retire, done pulse, counter++
// S7    | halt opcode or overflow trap
module reg_seq_ctrl
    import reg_seq_ctrl_pkg::*;
#(
    parameter int ADDRW = 4,
    parameter int OPW   = 4,
    parameter int CNTW  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    input  logic               overflow,
    input  logic               trap_clr,
    output logic [2:0]         pst,
    output logic [ADDRW-1:0]   Rd1,
    output logic [ADDRW-1:0]   Rd2,
    output logic [ADDRW-1:0]   Wr,
    output logic [OPW-1:0]     alu_op,
    output logic               Reg_Write,
    output logic               done,
    output logic               halted,
    output logic               ovf_trap,
    output logic [CNTW-1:0]    retired_cnt
);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [INSTR_W-1:0] r_instr;
    logic [CNTW-1:0]    r_cnt;
    logic               w_accept;
    logic               w_is_nop;
    logic               w_is_halt;
    logic [OPW-1:0]     w_op;
    logic [ADDRW-1:0]   w_rd1;
    logic [ADDRW-1:0]   w_rd2;
    logic [ADDRW-1:0]   w_wr;
    logic               w_ovf_hit;

    reg_seq_decode #(
        .ADDRW (ADDRW),
        .OPW   (OPW)
    ) u_decode (
        .i_instr   (r_instr),
        .o_op      (w_op),
        .o_rd1     (w_rd1),
        .o_rd2     (w_rd2),
        .o_wr      (w_wr),
        .o_is_nop  (w_is_nop),
        .o_is_halt (w_is_halt)
    );

    assign w_accept    = instr_valid && (r_state == S0);
    assign instr_ready = (r_state == S0);
    assign Reg_Write   = (r_state == S5) && !w_is_nop;
    assign done        = (r_state == S6);
    assign halted      = (r_state == S7);
    assign pst         = r_state;
    assign Rd1         = w_rd1;
    assign Rd2         = w_rd2;
    assign Wr          = w_wr;
    assign alu_op      = w_op;
    assign retired_cnt = r_cnt;

`ifdef OVF_TRAP_EN
    logic r_ovf_trap;

    // A $0 write is discarded by the register file, so its overflow cannot corrupt state
    assign w_ovf_hit = Reg_Write && (w_wr != '0) && overflow;
    assign ovf_trap  = r_ovf_trap;

    // Trap flag: set on overflow during a real write, cleared by trap_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_trap <= 1'b0;
        end else if (w_ovf_hit) begin
            r_ovf_trap <= 1'b1;
        end else if ((r_state == S7) && r_ovf_trap && trap_clr) begin
            r_ovf_trap <= 1'b0;
        end
    end
`else
    logic w_unused_trap;

    assign w_unused_trap = overflow ^ trap_clr;
    assign w_ovf_hit     = 1'b0;
    assign ovf_trap      = 1'b0;
`endif

    // Next-phase selection; a HALT opcode skips straight to S7
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S0: if (instr_valid) w_state_nxt = S1;
            S1: w_state_nxt = w_is_halt ? S7 : S2;
            S2: w_state_nxt = S3;
            S3: w_state_nxt = S4;
            S4: w_state_nxt = S5;
            S5: w_state_nxt = w_ovf_hit ? S7 : S6;
            S6: w_state_nxt = S0;
            S7: begin
`ifdef OVF_TRAP_EN
                if (r_ovf_trap && trap_clr) w_state_nxt = S0;
`endif
            end
            default: w_state_nxt = S0;
        endcase
    end

    // Phase register; reset aborts any sequence at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Instruction latch, loaded only on an accepted handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= '0;
        end else if (w_accept) begin
            r_instr <= instr;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S6) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Self-checking bench for reg_seq_ctrl (expectations follow OVF_TRAP_EN).
module tb_reg_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        overflow;
    logic        trap_clr;
    logic [2:0]  pst;
    logic [3:0]  Rd1;
    logic [3:0]  Rd2;
    logic [3:0]  Wr;
    logic [3:0]  alu_op;
    logic        Reg_Write;
    logic        done;
    logic        halted;
    logic        ovf_trap;
    logic [7:0]  retired_cnt;

    reg_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .overflow    (overflow),
        .trap_clr    (trap_clr),
        .pst         (pst),
        .Rd1         (Rd1),
        .Rd2         (Rd2),
        .Wr          (Wr),
        .alu_op      (alu_op),
        .Reg_Write   (Reg_Write),
        .done        (done),
        .halted      (halted),
        .ovf_trap    (ovf_trap),
        .retired_cnt (retired_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] word;
        logic [3:0]  op;
        logic [3:0]  rd1;
        logic [3:0]  rd2;
        logic [3:0]  wr;
        logic        we;
    } vec_t;

    vec_t        vecs[4];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [7:0]  exp_cnt = 8'd0;
    logic [15:0] b2b_words[3];
    int          acc_cyc[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        overflow    = 1'b0;
        trap_clr    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 8'd0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (pst != 3'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_ready", 32'(instr_ready), 32'd1);
    endtask

    // Accept one instruction and check every phase through the return to idle
    task automatic run_vec(input vec_t v);
        wait_idle();
        instr       = v.word;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'hBEEF;
        for (int k = 1; k <= 6; k++) begin
            chk("seq_pst", 32'(pst), 32'(k));
            chk("seq_we", 32'(Reg_Write), 32'((k == 5) && v.we));
            chk("seq_done", 32'(done), 32'(k == 6));
            if (k == 1 || k == 6) begin
                chk("seq_rd1", 32'(Rd1), 32'(v.rd1));
                chk("seq_rd2", 32'(Rd2), 32'(v.rd2));
                chk("seq_wr", 32'(Wr), 32'(v.wr));
                chk("seq_op", 32'(alu_op), 32'(v.op));
            end
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 8'd1;
        chk("end_pst", 32'(pst), 32'd0);
        chk("end_ready", 32'(instr_ready), 32'd1);
        chk("end_cnt", 32'(retired_cnt), 32'(exp_cnt));
        chk("idle_hold_rd1", 32'(Rd1), 32'(v.rd1));
    endtask

    initial begin
        vecs[0] = '{word: 16'h1235, op: 4'h1, rd1: 4'h2, rd2: 4'h3, wr: 4'h5, we: 1'b1};
        vecs[1] = '{word: 16'h0123, op: 4'h0, rd1: 4'h1, rd2: 4'h2, wr: 4'h3, we: 1'b0};
        vecs[2] = '{word: 16'h7BC0, op: 4'h7, rd1: 4'hB, rd2: 4'hC, wr: 4'h0, we: 1'b1};
        vecs[3] = '{word: 16'hA0F9, op: 4'hA, rd1: 4'h0, rd2: 4'hF, wr: 4'h9, we: 1'b1};
        b2b_words[0] = 16'h3456;
        b2b_words[1] = 16'h0789;
        b2b_words[2] = 16'h9ABC;

        // Reset values, checked while reset is still asserted
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        overflow    = 1'b0;
        trap_clr    = 1'b0;
        #12;
        chk("rst_pst", 32'(pst), 32'd0);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_we", 32'(Reg_Write), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_trap", 32'(ovf_trap), 32'd0);
        chk("rst_cnt", 32'(retired_cnt), 32'd0);
        chk("rst_addr", 32'({Rd1, Rd2, Wr, alu_op}), 32'd0);
        do_reset();

        // Table-driven single instructions
        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Back-to-back with valid held; words offered during busy phases are garbage
        begin
            int nacc  = 0;
            int ndone = 0;
            wait_idle();
            for (int cyc = 0; cyc < 40; cyc++) begin
                if (pst == 3'd1 && nacc > 0) begin
                    chk("b2b_rd1", 32'(Rd1), 32'(b2b_words[nacc-1][11:8]));
                    chk("b2b_wr", 32'(Wr), 32'(b2b_words[nacc-1][3:0]));
                end
                if (done) ndone++;
                if (pst == 3'd0 && nacc < 3) begin
                    instr        = b2b_words[nacc];
                    instr_valid  = 1'b1;
                    acc_cyc[nacc] = cyc;
                    nacc++;
                end else if (pst == 3'd0) begin
                    instr_valid = 1'b0;
                end else begin
                    instr = 16'hA9C4;
                end
                @(negedge clk);
            end
            instr_valid = 1'b0;
            exp_cnt = exp_cnt + 8'd3;
            chk("b2b_accepts", 32'(nacc), 32'd3);
            chk("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd7);
            chk("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd7);
            chk("b2b_done", 32'(ndone), 32'd3);
            chk("b2b_cnt", 32'(retired_cnt), 32'(exp_cnt));
        end

        // Overflow during a write to $7
        wait_idle();
        instr       = 16'h2347;
        instr_valid = 1'b1;
        overflow    = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("ovf_s5_pst", 32'(pst), 32'd5);
        chk("ovf_s5_we", 32'(Reg_Write), 32'd1);
        @(negedge clk);
`ifdef OVF_TRAP_EN
        chk("ovf_pst", 32'(pst), 32'd7);
        chk("ovf_trap", 32'(ovf_trap), 32'd1);
        chk("ovf_halted", 32'(halted), 32'd1);
        chk("ovf_done", 32'(done), 32'd0);
        overflow = 1'b0;
        trap_clr = 1'b1;
        @(negedge clk);
        trap_clr = 1'b0;
        chk("ovf_clr_pst", 32'(pst), 32'd0);
        chk("ovf_clr_trap", 32'(ovf_trap), 32'd0);
        chk("ovf_cnt", 32'(retired_cnt), 32'(exp_cnt));
`else
        chk("ovf_pst", 32'(pst), 32'd6);
        chk("ovf_done", 32'(done), 32'd1);
        chk("ovf_trap", 32'(ovf_trap), 32'd0);
        overflow = 1'b0;
        @(negedge clk);
        exp_cnt = exp_cnt + 8'd1;
        chk("ovf_cnt", 32'(retired_cnt), 32'(exp_cnt));
`endif

        // HALT opcode; later valid and trap_clr must not leave it
        wait_idle();
        instr       = 16'hF000;
        instr_valid = 1'b1;
        @(negedge clk);
        instr = 16'h1235;
        chk("halt_s1", 32'(pst), 32'd1);
        @(negedge clk);
        chk("halt_pst", 32'(pst), 32'd7);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_ready", 32'(instr_ready), 32'd0);
        trap_clr = 1'b1;
        repeat (5) @(negedge clk);
        chk("halt_stay", 32'(pst), 32'd7);
        chk("halt_no_latch", 32'({alu_op, Rd1, Rd2, Wr}), 32'h0000F000 & 32'h0000FFFF);
        chk("halt_cnt", 32'(retired_cnt), 32'(exp_cnt));
        chk("halt_we", 32'(Reg_Write), 32'd0);
        do_reset();
        chk("halt_rst_pst", 32'(pst), 32'd0);

        // Reset while in WRITE
        instr       = 16'h1235;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_s5_we", 32'(Reg_Write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pst", 32'(pst), 32'd0);
        chk("mid_rst_we", 32'(Reg_Write), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 8'd0;
        @(negedge clk);
        chk("mid_ready", 32'(instr_ready), 32'd1);
        chk("mid_cnt", 32'(retired_cnt), 32'd0);

        // Counter wrap: retire 255 NOPs, then one more
        begin
            int ndone = 0;
            int n     = 0;
            instr       = 16'h0000;
            instr_valid = 1'b1;
            while (ndone < 255 && n < 2000) begin
                @(negedge clk);
                if (done) ndone++;
                n++;
            end
            instr_valid = 1'b0;
            @(negedge clk);
            exp_cnt = 8'd255;
            chk("wrap_pre", 32'(retired_cnt), 32'd255);
            run_vec(vecs[1]);
            chk("wrap_zero", 32'(retired_cnt), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
